sap1_controller_sequencer: RTL and testbench

Control unit for the SAP-1 datapath. A 6-state ring counter (T1..T6) runs the fetch/execute cycle and decodes the 4-bit instruction-register opcode into the per-cycle control word. The control word drives PC, MAR, RAM, IR, the A and B registers, the add/sub ALU (its sub select) and the output register. Sits between the IR upper nibble and every datapath load/enable line.

---
 rtl/sap1_pkg.sv | 40 ++++
 rtl/sap1_controller_sequencer_if.sv | 34 +++
 rtl/sap1_ring_counter.sv | 56 +++++
 rtl/sap1_controller_sequencer.sv | 76 +++++++
 tb/tb_sap1_controller_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, T-state encodings and control-word bit positions.
package sap1_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned T_W  = 3;
  localparam int unsigned CW_W = 13;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [T_W-1:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } t_state_e;

  // Bit index of each control line inside a packed control word.
  typedef enum logic [3:0] {
    CW_PC_INC   = 4'd0,
    CW_PC_EN    = 4'd1,
    CW_MAR_LOAD = 4'd2,
    CW_RAM_EN   = 4'd3,
    CW_IR_LOAD  = 4'd4,
    CW_IR_EN    = 4'd5,
    CW_A_LOAD   = 4'd6,
    CW_A_EN     = 4'd7,
    CW_B_LOAD   = 4'd8,
    CW_ALU_EN   = 4'd9,
    CW_SUB      = 4'd10,
    CW_OUT_LOAD = 4'd11,
    CW_HALT     = 4'd12
  } cw_bit_e;

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Opcode/run inputs and control-word outputs between the SAP-1 sequencer and its datapath.
interface sap1_controller_sequencer_if;
  import sap1_pkg::*;

  logic            run;
  logic [OP_W-1:0] opcode;
  logic [T_W-1:0]  t_state;
  logic            pc_inc;
  logic            pc_en;
  logic            mar_load;
  logic            ram_en;
  logic            ir_load;
  logic            ir_en;
  logic            a_load;
  logic            a_en;
  logic            b_load;
  logic            alu_en;
  logic            sub;
  logic            out_load;
  logic            halt;

  modport master (
    output run, opcode,
    input  t_state, pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
           a_load, a_en, b_load, alu_en, sub, out_load, halt
  );

  modport slave (
    input  run, opcode,
    output t_state, pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
           a_load, a_en, b_load, alu_en, sub, out_load, halt
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// T1..T6 ring counter with run/pause, halt freeze and synchronous active-low reset.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run_i,
  input  logic           hlt_req_i,
  output logic [T_W-1:0] t_state_o,
  output logic           halted_o
);

  t_state_e t_q, t_d, t_nxt;
  logic     halted_q, halted_d;
  logic     t_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q      <= T1;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  // Corrupted encodings recover to T1; halt freezes; HLT in T4 latches the halted flag.
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    t_nxt    = T1;
    t_valid  = 1'b1;
    case (t_q)
      T1:      t_nxt = T2;
      T2:      t_nxt = T3;
      T3:      t_nxt = T4;
      T4:      t_nxt = T5;
      T5:      t_nxt = T6;
      T6:      t_nxt = T1;
      default: t_valid = 1'b0;
    endcase
    if (!t_valid) begin
      t_d = T1;
    end else if (halted_q) begin
      t_d = t_q;
    end else if (hlt_req_i) begin
      halted_d = 1'b1;
    end else if (run_i) begin
      t_d = t_nxt;
    end
  end

  assign t_state_o = t_q;
  assign halted_o  = halted_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: ring counter plus opcode decode into the per-T-state control word.
module sap1_controller_sequencer
  import sap1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  sap1_controller_sequencer_if.slave  bus
);

  logic [T_W-1:0]  t_state;
  logic            halted;
  logic            hlt_req_c;
  logic [CW_W-1:0] cw;

  assign hlt_req_c = (t_state == T4) && (bus.opcode == OP_HLT);

  sap1_ring_counter u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (bus.run),
    .hlt_req_i (hlt_req_c),
    .t_state_o (t_state),
    .halted_o  (halted)
  );

  // Control word is a pure decode of the registered state; pause and halt blank all but halt.
  always_comb begin
    cw = '0;
    if (!halted && bus.run) begin
      case (t_state)
        T1: begin cw[CW_PC_EN] = 1'b1; cw[CW_MAR_LOAD] = 1'b1; end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin cw[CW_RAM_EN] = 1'b1; cw[CW_IR_LOAD] = 1'b1; end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin cw[CW_IR_EN] = 1'b1; cw[CW_MAR_LOAD] = 1'b1; end
            OP_OUT: begin cw[CW_A_EN] = 1'b1; cw[CW_OUT_LOAD] = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin cw[CW_RAM_EN] = 1'b1; cw[CW_A_LOAD] = 1'b1; end
            OP_ADD, OP_SUB: begin cw[CW_RAM_EN] = 1'b1; cw[CW_B_LOAD] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw[CW_ALU_EN] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
            cw[CW_SUB]    = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
    cw[CW_HALT] = halted | hlt_req_c;
  end

  assign bus.t_state  = t_state;
  assign bus.pc_inc   = cw[CW_PC_INC];
  assign bus.pc_en    = cw[CW_PC_EN];
  assign bus.mar_load = cw[CW_MAR_LOAD];
  assign bus.ram_en   = cw[CW_RAM_EN];
  assign bus.ir_load  = cw[CW_IR_LOAD];
  assign bus.ir_en    = cw[CW_IR_EN];
  assign bus.a_load   = cw[CW_A_LOAD];
  assign bus.a_en     = cw[CW_A_EN];
  assign bus.b_load   = cw[CW_B_LOAD];
  assign bus.alu_en   = cw[CW_ALU_EN];
  assign bus.sub      = cw[CW_SUB];
  assign bus.out_load = cw[CW_OUT_LOAD];
  assign bus.halt     = cw[CW_HALT];

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer: vector table plus halt, pause, reset and invariant sequences.
module tb_sap1_controller_sequencer;
  import sap1_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sap1_controller_sequencer_if bus ();

  sap1_controller_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           run;
    logic [3:0]     op;
    logic [2:0]     exp_t;
    logic [12:0]    exp_cw;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] b(input cw_bit_e i);
    logic [12:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [12:0] cw_now();
    logic [12:0] m;
    m = '0;
    m[CW_PC_INC] = bus.pc_inc;   m[CW_PC_EN] = bus.pc_en;     m[CW_MAR_LOAD] = bus.mar_load;
    m[CW_RAM_EN] = bus.ram_en;   m[CW_IR_LOAD] = bus.ir_load; m[CW_IR_EN] = bus.ir_en;
    m[CW_A_LOAD] = bus.a_load;   m[CW_A_EN] = bus.a_en;       m[CW_B_LOAD] = bus.b_load;
    m[CW_ALU_EN] = bus.alu_en;   m[CW_SUB] = bus.sub;         m[CW_OUT_LOAD] = bus.out_load;
    m[CW_HALT] = bus.halt;
    return m;
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic run, input logic [3:0] op, input logic [2:0] t, input logic [12:0] cw);
    vec_t v;
    v.run = run; v.op = op; v.exp_t = t; v.exp_cw = cw;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] bb, input logic s);
    return s ? 8'(a - bb) : 8'(a + bb);
  endfunction

  logic [12:0] w_t1, w_t2, w_t3, w_fetch_op, w_none;
  logic [3:0]  opv;
  logic [12:0] drv;
  int          ndrv;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.run = 1'b1;
    bus.opcode = 4'h0;

    w_t1 = b(CW_PC_EN) | b(CW_MAR_LOAD);
    w_t2 = b(CW_PC_INC);
    w_t3 = b(CW_RAM_EN) | b(CW_IR_LOAD);
    w_fetch_op = b(CW_IR_EN) | b(CW_MAR_LOAD);
    w_none = '0;

    // LDA
    add(1, 4'h0, 1, w_t1); add(1, 4'h0, 2, w_t2); add(1, 4'h0, 3, w_t3);
    add(1, 4'h0, 4, w_fetch_op); add(1, 4'h0, 5, b(CW_RAM_EN) | b(CW_A_LOAD)); add(1, 4'h0, 6, w_none);
    // ADD
    add(1, 4'h1, 1, w_t1); add(1, 4'h1, 2, w_t2); add(1, 4'h1, 3, w_t3);
    add(1, 4'h1, 4, w_fetch_op); add(1, 4'h1, 5, b(CW_RAM_EN) | b(CW_B_LOAD));
    add(1, 4'h1, 6, b(CW_ALU_EN) | b(CW_A_LOAD));
    // SUB
    add(1, 4'h2, 1, w_t1); add(1, 4'h2, 2, w_t2); add(1, 4'h2, 3, w_t3);
    add(1, 4'h2, 4, w_fetch_op); add(1, 4'h2, 5, b(CW_RAM_EN) | b(CW_B_LOAD));
    add(1, 4'h2, 6, b(CW_ALU_EN) | b(CW_A_LOAD) | b(CW_SUB));
    // OUT
    add(1, 4'he, 1, w_t1); add(1, 4'he, 2, w_t2); add(1, 4'he, 3, w_t3);
    add(1, 4'he, 4, b(CW_A_EN) | b(CW_OUT_LOAD)); add(1, 4'he, 5, w_none); add(1, 4'he, 6, w_none);
    // NOP (0111)
    add(1, 4'h7, 1, w_t1); add(1, 4'h7, 2, w_t2); add(1, 4'h7, 3, w_t3);
    add(1, 4'h7, 4, w_none); add(1, 4'h7, 5, w_none); add(1, 4'h7, 6, w_none);
    // ADD paused three clocks in T5, then resumes
    add(1, 4'h1, 1, w_t1); add(1, 4'h1, 2, w_t2); add(1, 4'h1, 3, w_t3); add(1, 4'h1, 4, w_fetch_op);
    add(0, 4'h1, 5, w_none); add(0, 4'h1, 5, w_none); add(0, 4'h1, 5, w_none);
    add(1, 4'h1, 5, b(CW_RAM_EN) | b(CW_B_LOAD));
    add(1, 4'h1, 6, b(CW_ALU_EN) | b(CW_A_LOAD));
    add(1, 4'h1, 1, w_t1);

    // Reset state
    do_reset();
    chk("reset_t_state", 13'(bus.t_state), 13'd1);
    chk("reset_word", cw_now(), w_t1);

    foreach (vecs[i]) begin
      bus.run = vecs[i].run;
      bus.opcode = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_t_state", i), 13'(bus.t_state), 13'(vecs[i].exp_t));
      chk($sformatf("vec%0d_word", i), cw_now(), vecs[i].exp_cw);
      tick();
    end

    // ALU results driven by the sub select at T6 of SUB and ADD
    bus.run = 1'b1;
    bus.opcode = OP_SUB;
    do_reset();
    repeat (5) tick();
    chk("sub_t6_state", 13'(bus.t_state), 13'd6);
    chk("alu_31_minus_11", 13'(alu(8'd31, 8'd11, bus.sub)), 13'd20);
    chk("alu_10_minus_20", 13'(alu(8'd10, 8'd20, bus.sub)), 13'd246);
    bus.opcode = OP_ADD;
    #1;
    chk("alu_31_plus_11", 13'(alu(8'd31, 8'd11, bus.sub)), 13'd42);

    // HLT freezes in T4 until reset
    bus.opcode = OP_HLT;
    do_reset();
    repeat (3) tick();
    chk("hlt_t4_state", 13'(bus.t_state), 13'd4);
    chk("hlt_t4_word", cw_now(), b(CW_HALT));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("halted%0d_state", k), 13'(bus.t_state), 13'd4);
      chk($sformatf("halted%0d_word", k), cw_now(), b(CW_HALT));
    end
    bus.opcode = 4'h0;
    do_reset();
    chk("post_halt_reset_state", 13'(bus.t_state), 13'd1);
    chk("post_halt_reset_word", cw_now(), w_t1);

    // Reset mid-instruction in T5
    bus.opcode = OP_ADD;
    repeat (4) tick();
    chk("pre_reset_t5", 13'(bus.t_state), 13'd5);
    do_reset();
    chk("mid_reset_state", 13'(bus.t_state), 13'd1);
    chk("mid_reset_word", cw_now(), w_t1);

    // Bus-driver one-hot and sub/alu_en invariant across every opcode and state
    for (int op = 0; op < 16; op++) begin
      opv = 4'(op);
      bus.opcode = opv;
      do_reset();
      for (int s = 0; s < 6; s++) begin
        drv = cw_now() & (b(CW_PC_EN) | b(CW_RAM_EN) | b(CW_IR_EN) | b(CW_A_EN) | b(CW_ALU_EN));
        ndrv = $countones(drv);
        chk($sformatf("onehot_op%0d_s%0d", op, s), 13'(ndrv > 1), 13'd0);
        chk($sformatf("sub_alu_op%0d_s%0d", op, s), 13'(bus.sub && !bus.alu_en), 13'd0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
